mprc_beat_serializer: RTL and testbench

- Parametrised successor to the flow-through Grant serializer.
- Splits one wide TileLink-style Grant beat (DATA_W*RATIO bits) into RATIO narrow beats of DATA_W bits on the downstream channel.
- Header-only messages (no data) pass through unchanged in a single beat.
- Sits between the L2/outer Grant channel and a narrower inner client port. RATIO=1 degenerates to pure flow-through.

---
 rtl/mprc_beat_serializer.sv | 144 ++++++++++++++
 tb/tb_mprc_beat_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mprc_beat_serializer.sv
// Grant beat serializer: splits one wide Grant beat into RATIO narrow beats, slice 0 flows through.
// Optional MPRC_SER_STATS_EN adds wrapping message/stall counters.
module mprc_beat_serializer #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned RATIO  = 4,
  parameter  int unsigned AB_W   = 2,
  localparam int unsigned CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [AB_W-1:0]          io_in_bits_addr_beat,
  input  logic [1:0]               io_in_bits_client_xact_id,
  input  logic [3:0]               io_in_bits_manager_xact_id,
  input  logic                     io_in_bits_is_builtin_type,
  input  logic [3:0]               io_in_bits_g_type,
  input  logic                     io_in_bits_has_data,
  input  logic [DATA_W*RATIO-1:0]  io_in_bits_data,
  input  logic                     io_out_ready,
  output logic                     io_out_valid,
  output logic [AB_W+CNT_W-1:0]    io_out_bits_addr_beat,
  output logic [1:0]               io_out_bits_client_xact_id,
  output logic [3:0]               io_out_bits_manager_xact_id,
  output logic                     io_out_bits_is_builtin_type,
  output logic [3:0]               io_out_bits_g_type,
  output logic [DATA_W-1:0]        io_out_bits_data,
  output logic [CNT_W-1:0]         io_cnt,
  output logic                     io_done
`ifdef MPRC_SER_STATS_EN
  ,
  output logic [15:0]              io_stat_msgs,
  output logic [15:0]              io_stat_stalls
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [AB_W-1:0]               addr_beat_q;
  logic [1:0]                    client_id_q;
  logic [3:0]                    manager_id_q;
  logic                          builtin_q;
  logic [3:0]                    g_type_q;
  logic [RATIO-1:0][DATA_W-1:0]  payload_q;

  logic busy;
  logic in_fire;
  logic out_fire;
  logic last_slice;
  logic split;

  assign busy       = (state == BUSY);
  assign in_fire    = io_in_valid & io_in_ready;
  assign out_fire   = io_out_valid & io_out_ready;
  assign last_slice = (cnt == CNT_W'(RATIO - 1));
  assign split      = io_in_bits_has_data & (RATIO > 1);

  // In IDLE slice 0 and the header flow straight through; in BUSY everything comes from the capture registers.
  always_comb begin
    io_out_valid                = io_in_valid;
    io_in_ready                 = io_out_ready;
    io_out_bits_client_xact_id  = io_in_bits_client_xact_id;
    io_out_bits_manager_xact_id = io_in_bits_manager_xact_id;
    io_out_bits_is_builtin_type = io_in_bits_is_builtin_type;
    io_out_bits_g_type          = io_in_bits_g_type;
    io_out_bits_data            = io_in_bits_data[DATA_W-1:0];
    io_out_bits_addr_beat       = {io_in_bits_addr_beat, CNT_W'(0)};
    io_done                     = in_fire & ~split;
    if (busy) begin
      io_out_valid                = 1'b1;
      io_in_ready                 = 1'b0;
      io_out_bits_client_xact_id  = client_id_q;
      io_out_bits_manager_xact_id = manager_id_q;
      io_out_bits_is_builtin_type = builtin_q;
      io_out_bits_g_type          = g_type_q;
      io_out_bits_data            = payload_q[cnt];
      io_out_bits_addr_beat       = {addr_beat_q, cnt};
      io_done                     = out_fire & last_slice;
    end
  end

  assign io_cnt = cnt;

  // State, slice counter and message capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_beat_q  <= '0;
      client_id_q  <= '0;
      manager_id_q <= '0;
      builtin_q    <= 1'b0;
      g_type_q     <= '0;
      payload_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire && split) begin
            addr_beat_q  <= io_in_bits_addr_beat;
            client_id_q  <= io_in_bits_client_xact_id;
            manager_id_q <= io_in_bits_manager_xact_id;
            builtin_q    <= io_in_bits_is_builtin_type;
            g_type_q     <= io_in_bits_g_type;
            payload_q    <= io_in_bits_data;
            cnt          <= CNT_W'(1);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (out_fire) begin
            if (last_slice) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MPRC_SER_STATS_EN
  // Wrapping completed-message and downstream-stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_stat_msgs   <= '0;
      io_stat_stalls <= '0;
    end else begin
      if (io_done)
        io_stat_msgs <= io_stat_msgs + 16'd1;
      if (io_out_valid && !io_out_ready)
        io_stat_stalls <= io_stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mprc_beat_serializer.sv
// Self-checking bench for mprc_beat_serializer (DATA_W=32, RATIO=4): vector table plus scoreboard.
module tb_mprc_beat_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [1:0]   in_ab;
  logic [1:0]   in_cid;
  logic [3:0]   in_mid;
  logic         in_bt;
  logic [3:0]   in_gt;
  logic         in_hd;
  logic [127:0] in_data;
  logic         out_ready, out_valid;
  logic [3:0]   out_ab;
  logic [1:0]   out_cid;
  logic [3:0]   out_mid;
  logic         out_bt;
  logic [3:0]   out_gt;
  logic [31:0]  out_data;
  logic [1:0]   cnt;
  logic         done;
`ifdef MPRC_SER_STATS_EN
  logic [15:0]  stat_msgs, stat_stalls;
`endif

  mprc_beat_serializer dut (
    .clk                         (clk),
    .reset                       (reset),
    .io_in_valid                 (in_valid),
    .io_in_ready                 (in_ready),
    .io_in_bits_addr_beat        (in_ab),
    .io_in_bits_client_xact_id   (in_cid),
    .io_in_bits_manager_xact_id  (in_mid),
    .io_in_bits_is_builtin_type  (in_bt),
    .io_in_bits_g_type           (in_gt),
    .io_in_bits_has_data         (in_hd),
    .io_in_bits_data             (in_data),
    .io_out_ready                (out_ready),
    .io_out_valid                (out_valid),
    .io_out_bits_addr_beat       (out_ab),
    .io_out_bits_client_xact_id  (out_cid),
    .io_out_bits_manager_xact_id (out_mid),
    .io_out_bits_is_builtin_type (out_bt),
    .io_out_bits_g_type          (out_gt),
    .io_out_bits_data            (out_data),
    .io_cnt                      (cnt),
    .io_done                     (done)
`ifdef MPRC_SER_STATS_EN
    ,
    .io_stat_msgs                (stat_msgs),
    .io_stat_stalls              (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  ab;
    logic [1:0]  cnt;
    logic        done;
    logic [10:0] hdr;
    logic        in_rdy;
  } exp_beat_t;

  typedef struct {
    logic [1:0]   ab;
    logic         hd;
    logic [127:0] d;
    logic [10:0]  hdr;
    logic [31:0]  x_data;
    logic [3:0]   x_ab;
    logic         x_done;
  } vec_t;

  exp_beat_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_beats  = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: every downstream fire is compared with the oldest expected beat.
  always @(negedge clk) begin : mon
    exp_beat_t e;
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        n_beats++;
        check("beat_data", 64'(out_data), 64'(e.data));
        check("beat_addr_beat", 64'(out_ab), 64'(e.ab));
        check("beat_cnt", 64'(cnt), 64'(e.cnt));
        check("beat_done", 64'(done), 64'(e.done));
        check("beat_hdr", 64'({out_cid, out_mid, out_bt, out_gt}), 64'(e.hdr));
        check("beat_in_ready", 64'(in_ready), 64'(e.in_rdy));
      end
    end
  end

  // Push the expected beats of a message and present it upstream.
  task automatic drive(input logic [1:0] ab, input logic hd, input logic [127:0] d, input logic [10:0] hdr);
    exp_beat_t e;
    int nb;
    nb = hd ? 4 : 1;
    for (int k = 0; k < nb; k++) begin
      e.data   = d[k*32 +: 32];
      e.ab     = {ab, 2'(k)};
      e.cnt    = 2'(k);
      e.done   = (k == nb - 1);
      e.hdr    = hdr;
      e.in_rdy = (k == 0);
      sb.push_back(e);
    end
    in_valid = 1'b1;
    in_ab    = ab;
    in_hd    = hd;
    in_data  = d;
    {in_cid, in_mid, in_bt, in_gt} = hdr;
  endtask

  task automatic send(input logic [1:0] ab, input logic hd, input logic [127:0] d,
                      input logic [10:0] hdr, input bit keep);
    bit ok;
    ok = 1'b0;
    drive(ab, hd, d, hdr);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[4];
    int   t1, t2, b0;
`ifdef MPRC_SER_STATS_EN
    logic [15:0] s0;
`endif
    tbl[0] = '{2'd2, 1'b0, 128'h0, 11'h2A5, 32'h0, 4'b1000, 1'b1};
    tbl[1] = '{2'd0, 1'b1, 128'h44444444_33333333_22222222_11111111, 11'h13C,
               32'h11111111, 4'b0000, 1'b0};
    tbl[2] = '{2'd3, 1'b1, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 11'h7FF,
               32'h89ABCDEF, 4'b1100, 1'b0};
    tbl[3] = '{2'd1, 1'b0, 128'h0_0_0_5A5AA5A5, 11'h001, 32'h5A5AA5A5, 4'b0100, 1'b1};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ab = '0; in_cid = '0; in_mid = '0; in_bt = 1'b0; in_gt = '0; in_hd = 1'b0; in_data = '0;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    #1;
    check("rst_valid_follows", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Table: slice 0 must appear combinationally in the same cycle as the input.
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].ab, tbl[i].hd, tbl[i].d, tbl[i].hdr);
      @(negedge clk);
      check("tbl_out_valid", 64'(out_valid), 64'd1);
      check("tbl_in_ready", 64'(in_ready), 64'd1);
      check("tbl_data", 64'(out_data), 64'(tbl[i].x_data));
      check("tbl_addr_beat", 64'(out_ab), 64'(tbl[i].x_ab));
      check("tbl_done", 64'(done), 64'(tbl[i].x_done));
      check("tbl_cnt", 64'(cnt), 64'd0);
      check("tbl_hdr", 64'({out_cid, out_mid, out_bt, out_gt}), 64'(tbl[i].hdr));
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();
    end

    // Backpressure on slice 2 for three cycles.
`ifdef MPRC_SER_STATS_EN
    s0 = stat_stalls;
`endif
    send(2'd1, 1'b1, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 11'h155, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_cnt", 64'(cnt), 64'd2);
      check("bp_data", 64'(out_data), 64'h A2A2A2A2);
      check("bp_addr_beat", 64'(out_ab), 64'b0110);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
`ifdef MPRC_SER_STATS_EN
    check("stat_stalls", 64'(stat_stalls - s0), 64'd3);
    s0 = stat_msgs;
`endif

    // Back-to-back: second message accepted the cycle after the first completes.
    b0 = n_beats;
    send(2'd2, 1'b1, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 11'h0F0, 1'b1);
    t1 = cyc;
    send(2'd3, 1'b1, 128'h1D1D1D1D_1C1C1C1C_1B1B1B1B_1A1A1A1A, 11'h70F, 1'b0);
    t2 = cyc;
    check("b2b_accept_gap", 64'(t2 - t1), 64'd4);
    wait_drain();
    check("b2b_beats", 64'(n_beats - b0), 64'd8);
`ifdef MPRC_SER_STATS_EN
    check("stat_msgs", 64'(stat_msgs - s0), 64'd2);
`endif

    // Reset in the middle of a message drops the remaining slices.
    send(2'd0, 1'b1, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 11'h222, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_cnt", 64'(cnt), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(out_valid), 64'd0);
    check("post_rst_cnt", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    send(2'd2, 1'b0, 128'h0_0_0_77777777, 11'h3C3, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
